// File: rtl/cache_controller.sv
// Direct-mapped, write-through, no-write-allocate cache in front of an SRAM controller.
// Ports:
//   clk, rst                    : clock and asynchronous active-high reset
//   read_en, write_en, addr,
//   wdata, rdata, ready         : pipeline side; ready=0 freezes the pipeline
//   sram_read_en, sram_write_en,
//   sram_addr, sram_wdata,
//   sram_rdata, sram_ready      : SRAM controller side
//   hit_cnt, miss_cnt           : saturating read hit/miss counters
module cache_controller #(
    parameter int INDEX_W = 6,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             read_en,
    input  logic             write_en,
    input  logic [31:0]      addr,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata,
    output logic             ready,
    output logic             sram_read_en,
    output logic             sram_write_en,
    output logic [31:0]      sram_addr,
    output logic [31:0]      sram_wdata,
    input  logic [31:0]      sram_rdata,
    input  logic             sram_ready,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [CNT_W-1:0] miss_cnt
);

    localparam int SETS  = 1 << INDEX_W;
    localparam int TAG_W = 17 - INDEX_W;

    typedef enum logic [1:0] {
        IDLE,
        READ_MISS,
        WRITE
    } state_t;

    state_t state;

    logic [SETS-1:0]  valid;
    logic [TAG_W-1:0] tag_mem  [SETS];
    logic [31:0]      data_mem [SETS];

    logic [INDEX_W-1:0] index;
    logic [TAG_W-1:0]   tag;
    logic               hit;
    logic               fill;
    logic               wr_upd;
    logic               unused_addr;

    assign index = addr[INDEX_W+1:2];
    assign tag   = addr[18:INDEX_W+2];
    assign hit   = valid[index] && (tag_mem[index] == tag);

    // Upper address bits and byte offset do not take part in lookup.
    assign unused_addr = ^{addr[31:19], addr[1:0]};

    assign sram_addr     = addr;
    assign sram_wdata    = wdata;
    assign sram_read_en  = (state == READ_MISS);
    assign sram_write_en = (state == WRITE);

    assign fill   = (state == READ_MISS) && sram_ready;
    assign wr_upd = (state == WRITE) && sram_ready && hit;

    always_comb begin
        ready = 1'b0;
        rdata = 32'd0;
        unique case (state)
            IDLE: begin
                // A read outranks a simultaneous write.
                if (read_en) begin
                    ready = hit;
                    if (hit) rdata = data_mem[index];
                end else begin
                    ready = !write_en;
                end
            end
            READ_MISS: begin
                ready = sram_ready;
                if (sram_ready) rdata = sram_rdata;
            end
            WRITE: begin
                ready = sram_ready;
            end
            default: begin
                ready = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            valid    <= '0;
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (read_en) begin
                        if (hit) begin
                            if (hit_cnt != '1) hit_cnt <= hit_cnt + 1'b1;
                        end else begin
                            if (miss_cnt != '1) miss_cnt <= miss_cnt + 1'b1;
                            state <= READ_MISS;
                        end
                    end else if (write_en) begin
                        state <= WRITE;
                    end
                end
                READ_MISS: begin
                    if (sram_ready) begin
                        valid[index] <= 1'b1;
                        state        <= IDLE;
                    end
                end
                WRITE: begin
                    if (sram_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Arrays are not reset; gating with rst keeps an aborted miss
    // or write from touching them.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (fill) begin
                data_mem[index] <= sram_rdata;
                tag_mem[index]  <= tag;
            end else if (wr_upd) begin
                data_mem[index] <= wdata;
            end
        end
    end

endmodule

// File: tb/tb_cache_controller.sv
// Directed self-checking bench for cache_controller.
// Drives inputs on the falling edge and checks outputs shortly after.
module tb_cache_controller;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          read_en;
    logic          write_en;
    logic [31:0]   addr;
    logic [31:0]   wdata;
    logic [31:0]   rdata;
    logic          ready;
    logic          sram_read_en;
    logic          sram_write_en;
    logic [31:0]   sram_addr;
    logic [31:0]   sram_wdata;
    logic [31:0]   sram_rdata;
    logic          sram_ready;
    logic [CW-1:0] hit_cnt;
    logic [CW-1:0] miss_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    cache_controller #(.INDEX_W(6), .CNT_W(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .read_en      (read_en),
        .write_en     (write_en),
        .addr         (addr),
        .wdata        (wdata),
        .rdata        (rdata),
        .ready        (ready),
        .sram_read_en (sram_read_en),
        .sram_write_en(sram_write_en),
        .sram_addr    (sram_addr),
        .sram_wdata   (sram_wdata),
        .sram_rdata   (sram_rdata),
        .sram_ready   (sram_ready),
        .hit_cnt      (hit_cnt),
        .miss_cnt     (miss_cnt)
    );

    task automatic chk(input string t, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", t, got, exp);
        end
    endtask

    task automatic issue(input bit r, input bit w,
                         input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        read_en  = r;
        write_en = w;
        addr     = a;
        wdata    = d;
        #1;
    endtask

    // Called after a request entered a wait state; serves it from the SRAM.
    task automatic complete(input string t, input bit rd,
                            input logic [31:0] v);
        @(negedge clk);
        #1;
        chk({t, "_en"}, 32'(rd ? sram_read_en : sram_write_en), 32'd1);
        chk({t, "_other"}, 32'(rd ? sram_write_en : sram_read_en), 32'd0);
        chk({t, "_wait"}, 32'(ready), 32'd0);
        chk({t, "_saddr"}, sram_addr, addr);
        if (!rd) chk({t, "_swdata"}, sram_wdata, wdata);
        @(negedge clk);
        sram_ready = 1'b1;
        sram_rdata = v;
        #1;
        chk({t, "_done"}, 32'(ready), 32'd1);
        chk({t, "_rdata"}, rdata, rd ? v : 32'd0);
        @(negedge clk);
        sram_ready = 1'b0;
        sram_rdata = 32'd0;
        read_en    = 1'b0;
        write_en   = 1'b0;
        #1;
        chk({t, "_drop"}, 32'(sram_read_en | sram_write_en), 32'd0);
    endtask

    task automatic hit(input string t, input logic [31:0] a,
                       input logic [31:0] exp);
        issue(1'b1, 1'b0, a, 32'd0);
        chk({t, "_ready"}, 32'(ready), 32'd1);
        chk({t, "_rdata"}, rdata, exp);
        chk({t, "_sre"}, 32'(sram_read_en), 32'd0);
        @(negedge clk);
        read_en = 1'b0;
        #1;
        chk({t, "_idle_rdata"}, rdata, 32'd0);
    endtask

    initial begin
        rst        = 1'b1;
        read_en    = 1'b0;
        write_en   = 1'b0;
        addr       = 32'd0;
        wdata      = 32'd0;
        sram_rdata = 32'd0;
        sram_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_sre", 32'(sram_read_en), 32'd0);
        chk("rst_swe", 32'(sram_write_en), 32'd0);
        chk("rst_hit", 32'(hit_cnt), 32'd0);
        chk("rst_miss", 32'(miss_cnt), 32'd0);
        chk("rst_rdata", rdata, 32'd0);

        @(negedge clk);
        rst = 1'b0;
        // Cold miss on 0x400
        issue(1'b1, 1'b0, 32'h400, 32'd0);
        chk("rm1_ready", 32'(ready), 32'd0);
        chk("rm1_sre0", 32'(sram_read_en), 32'd0);
        complete("rm1", 1'b1, 32'h32);
        chk("rm1_miss", 32'(miss_cnt), 32'd1);
        hit("h1", 32'h400, 32'h32);
        chk("h1_cnt", 32'(hit_cnt), 32'd1);

        // Write hit updates the line
        issue(1'b0, 1'b1, 32'h400, 32'h77);
        chk("wr1_ready", 32'(ready), 32'd0);
        complete("wr1", 1'b0, 32'd0);
        hit("h2", 32'h400, 32'h77);

        // Write miss, same index: no allocation
        issue(1'b0, 1'b1, 32'h800, 32'h99);
        complete("wr2", 1'b0, 32'd0);
        hit("h3", 32'h400, 32'h77);
        chk("h3_cnt", 32'(hit_cnt), 32'd3);

        // Conflict miss replaces the line
        issue(1'b1, 1'b0, 32'h800, 32'd0);
        chk("rm2_ready", 32'(ready), 32'd0);
        complete("rm2", 1'b1, 32'hAB);
        hit("h4", 32'h800, 32'hAB);
        issue(1'b1, 1'b0, 32'h400, 32'd0);
        chk("evict_ready", 32'(ready), 32'd0);
        complete("rm3", 1'b1, 32'h32);
        chk("rm3_miss", 32'(miss_cnt), 32'd3);

        // Reset during a miss, with sram_ready high
        issue(1'b1, 1'b0, 32'h1004, 32'd0);
        @(negedge clk);
        #1;
        chk("ab_sre", 32'(sram_read_en), 32'd1);
        @(negedge clk);
        rst        = 1'b1;
        sram_ready = 1'b1;
        sram_rdata = 32'hDEAD;
        #1;
        chk("ab_sre0", 32'(sram_read_en), 32'd0);
        chk("ab_ready", 32'(ready), 32'd0);
        chk("ab_rdata", rdata, 32'd0);
        chk("ab_miss", 32'(miss_cnt), 32'd0);
        chk("ab_hit", 32'(hit_cnt), 32'd0);
        @(negedge clk);
        rst        = 1'b0;
        sram_ready = 1'b0;
        sram_rdata = 32'd0;
        #1;
        chk("ab_remiss", 32'(ready), 32'd0);
        complete("rm4", 1'b1, 32'h5);
        chk("rm4_miss", 32'(miss_cnt), 32'd1);
        issue(1'b1, 1'b0, 32'h400, 32'd0);
        chk("rm5_ready", 32'(ready), 32'd0);
        complete("rm5", 1'b1, 32'h32);

        // Read wins over a simultaneous write
        issue(1'b1, 1'b1, 32'h2008, 32'h1234);
        chk("both_ready", 32'(ready), 32'd0);
        complete("both", 1'b1, 32'hC0DE);
        chk("both_miss", 32'(miss_cnt), 32'd3);
        hit("h5", 32'h2008, 32'hC0DE);
        chk("h5_cnt", 32'(hit_cnt), 32'd1);

        // Hit counter saturates at all-ones
        for (int i = 0; i < 20; i++) hit("sat", 32'h400, 32'h32);
        chk("sat_hit", 32'(hit_cnt), 32'hF);
        chk("sat_miss", 32'(miss_cnt), 32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
